// File: rtl/drr_arb.sv
// Deficit round-robin packet arbiter: visits queues in turn, credits each visit
// with QUANTUM bytes and offers head packets while they fit in the deficit.
module drr_arb #(
  parameter int unsigned PKT_QS_CNT = 4,
  parameter int unsigned QUANTUM    = 500
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [PKT_QS_CNT-1:0]              q_val_i,
  input  logic [PKT_QS_CNT-1:0][15:0]        size_i,
  input  logic                               sel_rdy_i,
  output logic                               sel_val_o,
  output logic [$clog2(PKT_QS_CNT)-1:0]      sel_addr_o,
  output logic [15:0]                        sel_size_o,
  output logic                               round_o
);

  localparam int unsigned AW = $clog2(PKT_QS_CNT);
  localparam int unsigned DW = 17;
  localparam int unsigned SW = 16;
  localparam logic [DW-1:0] QUANT = DW'(QUANTUM);
  localparam logic [AW-1:0] LAST  = AW'(PKT_QS_CNT - 1);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [AW-1:0]                 ptr_q, ptr_d;
  logic [PKT_QS_CNT-1:0][DW-1:0] def_q, def_d;
  logic                          sel_val_q, sel_val_d;
  logic [AW-1:0]                 sel_addr_q, sel_addr_d;
  logic [SW-1:0]                 sel_size_q, sel_size_d;
  logic                          round_q, round_d;

  logic                          cur_val_c;
  logic [DW-1:0]                 cur_def_c;
  logic [DW-1:0]                 cur_size_c;
  logic                          wrap_c;

  assign cur_val_c  = q_val_i[ptr_q];
  assign cur_def_c  = def_q[ptr_q];
  assign cur_size_c = {1'b0, size_i[ptr_q]};
  assign wrap_c     = (ptr_q == LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    def_d      = def_q;
    sel_val_d  = sel_val_q;
    sel_addr_d = sel_addr_q;
    sel_size_d = sel_size_q;
    round_d    = 1'b0;

    case (state_q)
      SCAN: begin
        if (cur_val_c) begin
          def_d[ptr_q] = cur_def_c + QUANT;
          state_d      = CHECK;
        end else begin
          def_d[ptr_q] = '0;
          ptr_d        = ptr_q + AW'(1);
          round_d      = wrap_c;
        end
      end
      CHECK: begin
        if (!cur_val_c) begin
          def_d[ptr_q] = '0;
          ptr_d        = ptr_q + AW'(1);
          round_d      = wrap_c;
          state_d      = SCAN;
        end else if (cur_size_c <= cur_def_c) begin
          sel_val_d  = 1'b1;
          sel_addr_d = ptr_q;
          sel_size_d = size_i[ptr_q];
          state_d    = SEND;
        end else begin
          // Head does not fit: keep the credit for the next visit
          ptr_d   = ptr_q + AW'(1);
          round_d = wrap_c;
          state_d = SCAN;
        end
      end
      SEND: begin
        // Offer is frozen; inputs are ignored until the handshake
        if (sel_rdy_i) begin
          def_d[ptr_q] = cur_def_c - {1'b0, sel_size_q};
          sel_val_d    = 1'b0;
          state_d      = CHECK;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SCAN;
      ptr_q      <= '0;
      def_q      <= '0;
      sel_val_q  <= 1'b0;
      sel_addr_q <= '0;
      sel_size_q <= '0;
      round_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      def_q      <= def_d;
      sel_val_q  <= sel_val_d;
      sel_addr_q <= sel_addr_d;
      sel_size_q <= sel_size_d;
      round_q    <= round_d;
    end
  end

  assign sel_val_o  = sel_val_q;
  assign sel_addr_o = sel_addr_q;
  assign sel_size_o = sel_size_q;
  assign round_o    = round_q;

endmodule
